// File: rtl/rate_meter_if.sv
// Result channel of the rate meter: averaged period with valid/ready.
// The meter drives through master, the consumer sits on slave.
interface rate_meter_if #(
   parameter int PW = 10
);
   logic [PW-1:0] Period;
   logic          PeriodValid;
   logic          PeriodReady;

   modport master (
      output Period,
      output PeriodValid,
      input  PeriodReady
   );

   modport slave (
      input  Period,
      input  PeriodValid,
      output PeriodReady
   );
endinterface

// File: rtl/rate_meter.sv
// Measures cycles between rising edges of PulseIn, averages 2^AVG_LOG2
// periods and offers the result on a valid/ready channel.
module rate_meter #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_PERIOD  = 1023,
   parameter int AVG_LOG2    = 2
) (
   input  logic         ClockIn,
   input  logic         resetn,
   input  logic         PulseIn,
   input  logic         Clear,
   rate_meter_if.master po,
   output logic         Timeout,
   output logic         Overrun,
   output logic         Locked
);
   localparam int PW = $clog2(MAX_PERIOD + 1);
   localparam int AW = PW + AVG_LOG2;
   localparam int GW = AVG_LOG2 + 1;
   localparam logic [PW-1:0] MAXP  = PW'(MAX_PERIOD);
   localparam logic [GW-1:0] GLAST = GW'((1 << AVG_LOG2) - 1);

   typedef enum logic {S_IDLE, S_MEAS} state_t;

   logic synced;
   logic dly_d, dly_q;
   logic pulse_edge;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign synced = PulseIn;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_d, sync_q;
         always_comb sync_d = SYNC_STAGES'({sync_q, PulseIn});
         always_ff @(posedge ClockIn or negedge resetn)
            if (!resetn) sync_q <= '0;
            else         sync_q <= sync_d;
         assign synced = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // The delay flop belongs to the synchronizer, so Clear leaves it alone.
   always_comb dly_d = synced;
   always_ff @(posedge ClockIn or negedge resetn)
      if (!resetn) dly_q <= 1'b0;
      else         dly_q <= dly_d;

   assign pulse_edge = synced & ~dly_q;

   state_t        state_d, state_q;
   logic [PW-1:0] cnt_d, cnt_q;
   logic [AW-1:0] acc_d, acc_q;
   logic [GW-1:0] grp_d, grp_q;
   logic [PW-1:0] res_d, res_q;
   logic          res_vld_d, res_vld_q;
   logic [PW-1:0] period_d, period_q;
   logic          pvld_d, pvld_q;
   logic          tmo_d, tmo_q;
   logic          ovr_d, ovr_q;
   logic          lock_d, lock_q;
   logic [AW-1:0] sum_w;

   assign sum_w = acc_q + AW'(cnt_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      grp_d     = grp_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      period_d  = period_q;
      pvld_d    = pvld_q;
      tmo_d     = tmo_q;
      ovr_d     = ovr_q;
      lock_d    = lock_q;

      unique case (state_q)
         S_IDLE: begin
            if (pulse_edge) begin
               cnt_d   = PW'(1);
               tmo_d   = 1'b0;
               state_d = S_MEAS;
            end
         end
         S_MEAS: begin
            if (pulse_edge) begin
               cnt_d = PW'(1);
               if (grp_q == GLAST) begin
                  res_d     = PW'(sum_w >> AVG_LOG2);
                  res_vld_d = 1'b1;
                  acc_d     = '0;
                  grp_d     = '0;
               end else begin
                  acc_d = sum_w;
                  grp_d = grp_q + GW'(1);
               end
            end else if (cnt_q == MAXP) begin
               tmo_d   = 1'b1;
               lock_d  = 1'b0;
               cnt_d   = '0;
               acc_d   = '0;
               grp_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Output slot: a pending result loads unless the slot is held.
      if (pvld_q && po.PeriodReady) pvld_d = 1'b0;
      if (res_vld_q) begin
         if (!pvld_q || po.PeriodReady) begin
            period_d = res_q;
            pvld_d   = 1'b1;
            lock_d   = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end

      if (Clear) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         acc_d     = '0;
         grp_d     = '0;
         res_d     = '0;
         res_vld_d = 1'b0;
         period_d  = '0;
         pvld_d    = 1'b0;
         tmo_d     = 1'b0;
         ovr_d     = 1'b0;
         lock_d    = 1'b0;
      end
   end

   always_ff @(posedge ClockIn or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         grp_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         period_q  <= '0;
         pvld_q    <= 1'b0;
         tmo_q     <= 1'b0;
         ovr_q     <= 1'b0;
         lock_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         grp_q     <= grp_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         period_q  <= period_d;
         pvld_q    <= pvld_d;
         tmo_q     <= tmo_d;
         ovr_q     <= ovr_d;
         lock_q    <= lock_d;
      end
   end

   assign po.Period      = period_q;
   assign po.PeriodValid = pvld_q;
   assign Timeout        = tmo_q;
   assign Overrun        = ovr_q;
   assign Locked         = lock_q;
endmodule

// File: tb/tb_rate_meter.sv
// Directed bench: dut_a (no sync, no averaging) and dut_b (2 sync
// stages, average of 4) share one pulse stream.
module tb_rate_meter;
   logic clk = 1'b0;
   logic resetn;
   logic pulse;
   logic clr;
   logic tmo_a, ovr_a, lck_a;
   logic tmo_b, ovr_b, lck_b;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   int a_xfer = 0, a_last = 0, a_vhi = 0, a_rise = 0, a_trise = 0;
   int b_xfer = 0, b_last = 0, b_rise = 0, b_trise = 0;
   logic a_pv = 1'b0, b_pv = 1'b0, a_pt = 1'b0, b_pt = 1'b0;
   int rise_c = 0;

   rate_meter_if #(.PW(10)) ifa ();
   rate_meter_if #(.PW(10)) ifb ();

   rate_meter #(.SYNC_STAGES(0), .MAX_PERIOD(1023), .AVG_LOG2(0)) dut_a (
      .ClockIn(clk), .resetn(resetn), .PulseIn(pulse), .Clear(clr),
      .po(ifa), .Timeout(tmo_a), .Overrun(ovr_a), .Locked(lck_a)
   );

   rate_meter #(.SYNC_STAGES(2), .MAX_PERIOD(1023), .AVG_LOG2(2)) dut_b (
      .ClockIn(clk), .resetn(resetn), .PulseIn(pulse), .Clear(clr),
      .po(ifb), .Timeout(tmo_b), .Overrun(ovr_b), .Locked(lck_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ifa.PeriodValid) a_vhi = a_vhi + 1;
      if (ifa.PeriodValid && ifa.PeriodReady) begin
         a_xfer = a_xfer + 1;
         a_last = int'(ifa.Period);
      end
      if (ifb.PeriodValid && ifb.PeriodReady) begin
         b_xfer = b_xfer + 1;
         b_last = int'(ifb.Period);
      end
      if (ifa.PeriodValid && !a_pv) a_rise = cyc;
      if (ifb.PeriodValid && !b_pv) b_rise = cyc;
      if (tmo_a && !a_pt) a_trise = cyc;
      if (tmo_b && !b_pt) b_trise = cyc;
      a_pv = ifa.PeriodValid;
      b_pv = ifb.PeriodValid;
      a_pt = tmo_a;
      b_pt = tmo_b;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk = n_chk + 1;
      if (obs == exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lo(input int n);
      pulse = 1'b0;
      repeat (n) tick();
   endtask

   task automatic rise();
      pulse = 1'b1;
      rise_c = cyc;
      tick();
      pulse = 1'b0;
   endtask

   task automatic gap(input int n);
      rise();
      lo(n - 1);
   endtask

   task automatic sq(input int n, input int h);
      pulse = 1'b1;
      repeat (h) tick();
      lo(n - h);
   endtask

   task automatic do_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   int xa, xb, va;

   initial begin
      resetn = 1'b0;
      pulse  = 1'b0;
      clr    = 1'b0;
      ifa.PeriodReady = 1'b1;
      ifb.PeriodReady = 1'b1;
      repeat (3) tick();
      chk("rst_period", int'(ifa.Period), 0);
      chk("rst_valid", int'(ifa.PeriodValid), 0);
      chk("rst_tmo", int'(tmo_b), 0);
      chk("rst_lock", int'(lck_a), 0);
      resetn = 1'b1;
      repeat (3) tick();

      xa = a_xfer; va = a_vhi;
      gap(500);
      chk("t1_first_no_res", a_xfer - xa, 0);
      repeat (3) gap(500);
      chk("t1_xfers", a_xfer - xa, 3);
      chk("t1_valid_cycles", a_vhi - va, 3);
      chk("t1_period", a_last, 500);
      chk("t1_lock_a", int'(lck_a), 1);
      chk("t1_lock_b", int'(lck_b), 0);
      chk("t1_tmo", int'(tmo_a), 0);
      chk("t1_ovr", int'(ovr_a), 0);

      do_clear();
      chk("clr_period", int'(ifa.Period), 0);
      chk("clr_lock", int'(lck_a), 0);

      xa = a_xfer; xb = b_xfer;
      gap(499); gap(501); gap(500); gap(503);
      rise();
      lo(19);
      chk("t2_a_xfers", a_xfer - xa, 4);
      chk("t2_a_last", a_last, 503);
      chk("t2_b_xfers", b_xfer - xb, 1);
      chk("t2_b_avg", b_last, 500);
      chk("t2_a_lat", a_rise - rise_c, 2);
      chk("t2_b_lat", b_rise - rise_c, 4);

      lo(1100);
      chk("t3_a_tmo_at", a_trise - rise_c, 1024);
      chk("t3_b_tmo_at", b_trise - rise_c, 1026);
      chk("t3_tmo", int'(tmo_a), 1);
      chk("t3_lock_a", int'(lck_a), 0);
      chk("t3_lock_b", int'(lck_b), 0);
      xb = b_xfer;
      gap(300);
      chk("t3_tmo_clr_a", int'(tmo_a), 0);
      chk("t3_tmo_clr_b", int'(tmo_b), 0);
      repeat (3) gap(300);
      chk("t3_b_wait_grp", b_xfer - xb, 0);
      gap(300);
      chk("t3_b_xfers", b_xfer - xb, 1);
      chk("t3_b_avg", b_last, 300);
      chk("t3_lock_b2", int'(lck_b), 1);

      do_clear();
      ifa.PeriodReady = 1'b0;
      xa = a_xfer;
      gap(100); gap(200);
      rise();
      lo(149);
      chk("t4_held", int'(ifa.Period), 100);
      chk("t4_valid", int'(ifa.PeriodValid), 1);
      chk("t4_ovr", int'(ovr_a), 1);
      ifa.PeriodReady = 1'b1;
      tick();
      chk("t4_one_xfer", a_xfer - xa, 1);
      chk("t4_xfer_val", a_last, 100);
      chk("t4_valid_drop", int'(ifa.PeriodValid), 0);
      lo(149);
      gap(20);
      chk("t4_next", a_last, 300);
      chk("t4_ovr_sticky", int'(ovr_a), 1);
      chk("t4_b_ovr", int'(ovr_b), 0);

      do_clear();
      gap(1023);
      gap(20);
      chk("t5_maxp", a_last, 1023);
      chk("t5_tmo_a", int'(tmo_a), 0);
      chk("t5_tmo_b", int'(tmo_b), 0);

      do_clear();
      repeat (3) gap(100);
      resetn = 1'b0;
      #1;
      chk("t6_rst_period", int'(ifa.Period), 0);
      chk("t6_rst_lock", int'(lck_a), 0);
      tick();
      resetn = 1'b1;
      tick();
      xa = a_xfer; xb = b_xfer;
      sq(64, 1);
      chk("t6_start_edge", a_xfer - xa, 0);
      repeat (3) sq(64, 40);
      chk("t6_b_wait_grp", b_xfer - xb, 0);
      sq(64, 40);
      chk("t6_b_avg", b_last, 64);
      chk("t6_a_sq", a_last, 64);

      pulse = 1'b1;
      repeat (2000) tick();
      chk("t6_stuck_tmo_a", int'(tmo_a), 1);
      chk("t6_stuck_tmo_b", int'(tmo_b), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
